// File: rtl/hazard_ctrl.sv
// Hazard control unit: shadow E/M/W scoreboard, D-stage stall/forward decisions
// and the mult/div busy countdown that holds HI/LO readers in D.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_T_use_rs,
    input  logic [1:0] D_T_use_rt,
    input  logic [4:0] D_WriteRegAddr,
    input  logic       D_RegWrite,
    input  logic [1:0] D_T_new,
    input  logic       D_is_md,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       HCU_EN_PC,
    output logic       HCU_EN_FD,
    output logic       HCU_EN_DE,
    output logic       HCU_clr_DE,
    output logic [1:0] D_fwd_rs,
    output logic [1:0] D_fwd_rt,
    output logic       md_busy
);

    localparam logic [3:0] LP_MULT_CNT = MULT_CYCLES[3:0];
    localparam logic [3:0] LP_DIV_CNT  = DIV_CYCLES[3:0];

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [1:0] tnew;
    } sb_entry_t;

    sb_entry_t  r_sb_e;
    sb_entry_t  r_sb_m;
    sb_entry_t  r_sb_w;
    logic [3:0] r_md_cnt;

    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall_md;
    logic       w_stall;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // First valid match wins. A W entry has always drained to tnew=0, so a W
    // hit never stalls; the GRF write-through bypass covers it.
    function automatic logic op_stall(input logic [4:0] addr, input logic [1:0] t_use,
                                      input sb_entry_t e, input sb_entry_t m,
                                      input sb_entry_t w);
        if (addr == 5'd0 || t_use == 2'd3) return 1'b0;
        if (e.valid && e.addr == addr) return e.tnew > t_use;
        if (m.valid && m.addr == addr) return m.tnew > t_use;
        if (w.valid && w.addr == addr) return w.tnew > t_use;
        return 1'b0;
    endfunction

    function automatic logic [1:0] op_fwd(input logic [4:0] addr,
                                          input sb_entry_t e, input sb_entry_t m);
        if (addr == 5'd0) return 2'd0;
        if (e.valid && e.addr == addr && e.tnew == 2'd0) return 2'd1;
        if (m.valid && m.addr == addr && m.tnew == 2'd0) return 2'd2;
        return 2'd0;
    endfunction

    assign md_busy = (r_md_cnt != 4'd0);

    always_comb begin
        w_stall_rs = op_stall(D_rs, D_T_use_rs, r_sb_e, r_sb_m, r_sb_w);
        w_stall_rt = op_stall(D_rt, D_T_use_rt, r_sb_e, r_sb_m, r_sb_w);
        w_stall_md = D_is_md && (md_busy || E_md_start);
        w_stall    = w_stall_rs | w_stall_rt | w_stall_md;
    end

    // D/E clear has priority over its enable, so D/E stays enabled while stalling.
    always_comb begin
        HCU_EN_PC  = ~w_stall;
        HCU_EN_FD  = ~w_stall;
        HCU_EN_DE  = 1'b1;
        HCU_clr_DE = w_stall;
        D_fwd_rs   = op_fwd(D_rs, r_sb_e, r_sb_m);
        D_fwd_rt   = op_fwd(D_rt, r_sb_e, r_sb_m);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_e   <= '0;
            r_sb_m   <= '0;
            r_sb_w   <= '0;
            r_md_cnt <= 4'd0;
        end else begin
            r_sb_m <= '{valid: r_sb_e.valid, addr: r_sb_e.addr, tnew: sat_dec(r_sb_e.tnew)};
            r_sb_w <= '{valid: r_sb_m.valid, addr: r_sb_m.addr, tnew: sat_dec(r_sb_m.tnew)};
            if (w_stall) begin
                r_sb_e <= '0;
            end else begin
                r_sb_e <= '{valid: D_RegWrite && (D_WriteRegAddr != 5'd0),
                            addr:  D_WriteRegAddr,
                            tnew:  sat_dec(D_T_new)};
            end
            // A start while busy is ignored; the running count carries on.
            if (E_md_start && r_md_cnt == 4'd0) begin
                r_md_cnt <= E_md_is_div ? LP_DIV_CNT : LP_MULT_CNT;
            end else if (r_md_cnt != 4'd0) begin
                r_md_cnt <= r_md_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus a random run against
// a cycle model of the scoreboard and the mult/div countdown.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_T_use_rs;
    logic [1:0] D_T_use_rt;
    logic [4:0] D_WriteRegAddr;
    logic       D_RegWrite;
    logic [1:0] D_T_new;
    logic       D_is_md;
    logic       E_md_start;
    logic       E_md_is_div;
    logic       HCU_EN_PC;
    logic       HCU_EN_FD;
    logic       HCU_EN_DE;
    logic       HCU_clr_DE;
    logic [1:0] D_fwd_rs;
    logic [1:0] D_fwd_rt;
    logic       md_busy;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt),
        .D_T_use_rs(D_T_use_rs), .D_T_use_rt(D_T_use_rt),
        .D_WriteRegAddr(D_WriteRegAddr), .D_RegWrite(D_RegWrite),
        .D_T_new(D_T_new), .D_is_md(D_is_md),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .HCU_EN_PC(HCU_EN_PC), .HCU_EN_FD(HCU_EN_FD),
        .HCU_EN_DE(HCU_EN_DE), .HCU_clr_DE(HCU_clr_DE),
        .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {EN_PC, EN_FD, EN_DE, clr_DE, fwd_rs, fwd_rt, md_busy}
    logic [8:0] obs;
    assign obs = {HCU_EN_PC, HCU_EN_FD, HCU_EN_DE, HCU_clr_DE, D_fwd_rs, D_fwd_rt, md_busy};

    logic [8:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, wa;
        logic [1:0] urs, urt, tnew;
        logic       rw, md, start, div;
        logic [8:0] exp;
    } vec_t;

    function automatic logic [8:0] exp_vec(input logic st, input logic [1:0] frs,
                                           input logic [1:0] frt, input logic busy);
        return {~st, ~st, 1'b1, st, frs, frt, busy};
    endfunction

    function automatic vec_t mk(input int rst, input int rs, input int urs, input int rt,
                                input int urt, input int wa, input int rw, input int tnew,
                                input int md, input int start, input int div,
                                input int st, input int frs, input int frt, input int busy);
        vec_t v;
        v.rst = 1'(rst);  v.rs = 5'(rs);   v.urs = 2'(urs);  v.rt = 5'(rt);
        v.urt = 2'(urt);  v.wa = 5'(wa);   v.rw = 1'(rw);    v.tnew = 2'(tnew);
        v.md = 1'(md);    v.start = 1'(start); v.div = 1'(div);
        v.exp = exp_vec(1'(st), 2'(frs), 2'(frt), 1'(busy));
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; D_rs = v.rs; D_rt = v.rt; D_T_use_rs = v.urs; D_T_use_rt = v.urt;
        D_WriteRegAddr = v.wa; D_RegWrite = v.rw; D_T_new = v.tnew;
        D_is_md = v.md; E_md_start = v.start; E_md_is_div = v.div;
    endtask

    task automatic flush();
        drive(mk(0, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,0));
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,0));
        v.push_back(mk(0, 8,0,9,0, 0,0,0, 1,0,0, 0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_stall();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 8,1,3, 0,0,0, 0,0,0,0));  // lw $8 enters E
        v.push_back(mk(0, 8,0,0,3, 0,0,0, 0,0,0, 1,0,0,0));  // E tnew=2
        v.push_back(mk(0, 8,0,0,3, 0,0,0, 0,0,0, 1,0,0,0));  // M tnew=1
        v.push_back(mk(0, 8,0,0,3, 0,0,0, 0,0,0, 0,0,0,0));  // in W
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL lw_stall step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 9,1,1, 0,0,0, 0,0,0,0));  // addu $9
        v.push_back(mk(0, 9,1,0,3, 0,0,0, 0,0,0, 0,1,0,0));  // E fwd
        v.push_back(mk(0, 0,3,9,0, 0,0,0, 0,0,0, 0,0,2,0));  // M fwd
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL forward step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 0,1,3, 0,0,0, 0,0,0,0));
        for (int k = 0; k < 3; k++) v.push_back(mk(0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL zero_reg step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_md();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 1,1,0, 1,0,0,0));  // mult start + mfhi in D
        for (int k = 0; k < 5; k++) v.push_back(mk(0, 0,3,0,3, 0,0,0, 1,0,0, 1,0,0,1));
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 1,0,0, 0,0,0,0));
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,1,1, 0,0,0,0));  // div start
        for (int k = 0; k < 10; k++) begin
            if (k == 2) v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,1,0, 0,0,0,1));  // ignored start
            else        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,1));
        end
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 1,0,0, 0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL md_countdown step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 5,1,0, 0,0,0, 0,0,0,0));
        v.push_back(mk(0, 0,3,0,3, 5,1,1, 0,0,0, 0,0,0,0));
        v.push_back(mk(0, 0,3,5,0, 0,0,0, 0,0,0, 0,0,1,0));  // E and M both hit
        v.push_back(mk(0, 0,3,5,0, 0,0,0, 0,0,0, 0,0,2,0));
        v.push_back(mk(0, 0,3,0,3, 6,1,0, 0,0,0, 0,0,0,0));
        v.push_back(mk(0, 0,3,0,3, 6,1,3, 0,0,0, 0,0,0,0));
        v.push_back(mk(0, 6,1,0,3, 0,0,0, 0,0,0, 1,2,0,0));  // E tnew=2 blocks, M ready
        v.push_back(mk(0, 6,1,0,3, 0,0,0, 0,0,0, 0,0,0,0));  // M tnew=1 <= T_use
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL priority step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        logic [8:0] e;
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,1,1, 0,0,0,0));  // div start
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,1));  // cnt 10
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,1));  // cnt 9
        v.push_back(mk(0, 0,3,0,3, 8,1,3, 0,0,0, 0,0,0,1));  // cnt 8, lw $8
        v.push_back(mk(1, 8,0,0,3, 0,0,0, 1,0,0, 1,0,0,1));  // cnt 7, stalled, reset
        v.push_back(mk(0, 8,0,0,3, 0,0,0, 1,0,0, 0,0,0,0));
        v.push_back(mk(0, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,0));
        foreach (v[i]) begin
            drive(v[i]);
            exp_q.push_back(v[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_mid step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reference model state: index 0 = E, 1 = M, 2 = W
    logic       m_v[3];
    logic [4:0] m_a[3];
    logic [1:0] m_t[3];
    int         m_cnt;

    function automatic logic [1:0] m_dec(input logic [1:0] x);
        if (x == 2'd0) return 2'd0;
        return x - 2'd1;
    endfunction

    function automatic logic m_stall(input logic [4:0] a, input logic [1:0] u);
        if (a == 5'd0 || u == 2'd3) return 1'b0;
        for (int s = 0; s < 2; s++)
            if (m_v[s] && m_a[s] == a) return m_t[s] > u;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] a);
        if (a == 5'd0) return 2'd0;
        if (m_v[0] && m_a[0] == a && m_t[0] == 2'd0) return 2'd1;
        if (m_v[1] && m_a[1] == a && m_t[1] == 2'd0) return 2'd2;
        return 2'd0;
    endfunction

    task automatic test_random();
        vec_t v;
        logic st;
        logic [8:0] e;
        drive(mk(1, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,0));
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin m_v[s] = 1'b0; m_a[s] = 5'd0; m_t[s] = 2'd0; end
        m_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            v = mk(0, $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
                   $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
                   $urandom_range(0,3), ($urandom_range(0,3) == 0) ? 1 : 0,
                   ($urandom_range(0,5) == 0) ? 1 : 0, $urandom_range(0,1), 0,0,0,0);
            st = m_stall(v.rs, v.urs) | m_stall(v.rt, v.urt) |
                 (v.md && (m_cnt != 0 || v.start));
            exp_q.push_back(exp_vec(st, m_fwd(v.rs), m_fwd(v.rt), m_cnt != 0));
            drive(v);
            @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL random cycle %0d: got %b expected %b", i, obs, e);
            end
            m_v[2] = m_v[1]; m_a[2] = m_a[1]; m_t[2] = m_dec(m_t[1]);
            m_v[1] = m_v[0]; m_a[1] = m_a[0]; m_t[1] = m_dec(m_t[0]);
            if (st) begin
                m_v[0] = 1'b0;
            end else begin
                m_v[0] = v.rw && (v.wa != 5'd0);
                m_a[0] = v.wa;
                m_t[0] = m_dec(v.tnew);
            end
            if (v.start && m_cnt == 0) m_cnt = v.div ? 10 : 5;
            else if (m_cnt != 0)       m_cnt = m_cnt - 1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(mk(1, 0,3,0,3, 0,0,0, 0,0,0, 0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        flush(); test_lw_stall();
        flush(); test_forward();
        flush(); test_zero_reg();
        flush(); test_md();
        flush(); test_priority();
        flush(); test_reset_mid();
        flush(); test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
